// File: rtl/ms_timebase_if.sv
// Control/strobe bundle of the run-controlled millisecond time base.
// The master side drives the raw controls; the slave side returns run status and strobes.
interface ms_timebase_if;
  logic start;
  logic stop;
  logic clr;
  logic running;
  logic t_ms;
  logic t_10ms;
  logic t_100ms;
  logic t_1s;
  logic clr_out;

  modport master (
    output start, stop, clr,
    input  running, t_ms, t_10ms, t_100ms, t_1s, clr_out
  );

  modport slave (
    input  start, stop, clr,
    output running, t_ms, t_10ms, t_100ms, t_1s, clr_out
  );
endinterface

// File: rtl/ms_timebase.sv
// Run-controlled time base: synchronised START/STOP/CLR drive an IDLE/RUN/PAUSE FSM, and a
// prescaler plus decade cascade emit 1 ms / 10 ms / 100 ms / 1 s toggle-enable strobes.
module ms_timebase_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic warm_i,
  input  logic d_i,
  output logic edge_o
);
  logic [2:0] s_q;

  // Until warm, sync3 loads alongside sync2 so a level present at reset release gives no edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q <= '0;
    end else begin
      s_q[0] <= d_i;
      s_q[1] <= s_q[0];
      s_q[2] <= warm_i ? s_q[1] : s_q[0];
    end
  end

  assign edge_o = s_q[1] & ~s_q[2];
endmodule

module ms_timebase #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ms_timebase_if.slave   bus
);
  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e        state_q, state_d;
  logic [1:0]    warm_q;
  logic [2:0]    raw, edges;
  logic          start_e, stop_e, clr_e;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    d10_q, d10_d, d100_q, d100_d, d1000_q, d1000_d;
  logic [3:0]    strb_q, strb_d;
  logic          clr_out_q;
  logic          run_en, wrap;

  assign raw = {bus.clr, bus.stop, bus.start};

  ms_timebase_sync u_sync [2:0] (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .warm_i (warm_q[1]),
    .d_i    (raw),
    .edge_o (edges)
  );

  assign {clr_e, stop_e, start_e} = edges;

  always_comb begin
    state_d = state_q;
    if (clr_e) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_e) state_d = RUN;
        RUN:     if (stop_e)  state_d = PAUSE;
        PAUSE:   if (start_e) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counting stops on the same edge the FSM leaves RUN, so a wrap there never strobes.
  assign run_en = (state_q == RUN) && (state_d == RUN);
  assign wrap   = (cnt_q == DIV_M1);

  always_comb begin
    cnt_d   = cnt_q;
    d10_d   = d10_q;
    d100_d  = d100_q;
    d1000_d = d1000_q;
    strb_d  = '0;
    if (state_d == IDLE) begin
      cnt_d   = '0;
      d10_d   = '0;
      d100_d  = '0;
      d1000_d = '0;
    end else if (run_en) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      if (wrap) begin
        strb_d[0] = 1'b1;
        strb_d[1] = (d10_q == 4'd9);
        strb_d[2] = strb_d[1] && (d100_q == 4'd9);
        strb_d[3] = strb_d[2] && (d1000_q == 4'd9);
        d10_d     = (d10_q == 4'd9) ? 4'd0 : d10_q + 4'd1;
        if (strb_d[1]) d100_d  = (d100_q == 4'd9) ? 4'd0 : d100_q + 4'd1;
        if (strb_d[2]) d1000_d = (d1000_q == 4'd9) ? 4'd0 : d1000_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      warm_q    <= '0;
      cnt_q     <= '0;
      d10_q     <= '0;
      d100_q    <= '0;
      d1000_q   <= '0;
      strb_q    <= '0;
      clr_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      warm_q    <= {warm_q[0], 1'b1};
      cnt_q     <= cnt_d;
      d10_q     <= d10_d;
      d100_q    <= d100_d;
      d1000_q   <= d1000_d;
      strb_q    <= strb_d;
      clr_out_q <= clr_e;
    end
  end

  assign bus.running = (state_q == RUN);
  assign bus.t_ms    = strb_q[0];
  assign bus.t_10ms  = strb_q[1];
  assign bus.t_100ms = strb_q[2];
  assign bus.t_1s    = strb_q[3];
  assign bus.clr_out = clr_out_q;
endmodule

// File: tb/tb_ms_timebase.sv
// Directed bench for ms_timebase at DIV=10: run control, strobe cadence, pause, clear, reset.
module tb_ms_timebase;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ms_timebase_if bus ();

  ms_timebase #(.CLK_HZ(10_000), .TICK_HZ(1000)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [5:0] outs;
  logic [3:0] strb;
  assign outs = {bus.running, bus.t_ms, bus.t_10ms, bus.t_100ms, bus.t_1s, bus.clr_out};
  assign strb = outs[4:1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic quiet(input string tag, input int n);
    logic [5:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc |= outs;
    end
    chk(tag, 32'(acc), 32'h0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clr   = 1'b0;

    // reset with START toggling, released while START is high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = ~bus.start;
      if (i == 2) chk("rst_outs_mid", 32'(outs), 32'h0);
    end
    bus.start = 1'b1;
    @(negedge clk);
    chk("rst_outs", 32'(outs), 32'h0);
    rst_n = 1'b1;
    quiet("rst_hold_start", 10);
    bus.start = 1'b0;
    cyc(3);

    // basic run
    bus.start = 1'b1;
    cyc(2);
    chk("run_e2", 32'(bus.running), 32'h0);
    bus.start = 1'b0;
    cyc(1);
    chk("run_e3", 32'(bus.running), 32'h1);
    cyc(9);  chk("ms1_early", 32'(strb), 32'h0);
    cyc(1);  chk("ms1",       32'(strb), 32'h8);
    cyc(9);  chk("ms2_early", 32'(strb), 32'h0);
    cyc(1);  chk("ms2",       32'(strb), 32'h8);
    cyc(70); chk("ms9",       32'(strb), 32'h8);
    cyc(10); chk("ms10",      32'(strb), 32'hC);
    cyc(890); chk("ms99",     32'(strb), 32'h8);
    cyc(10); chk("ms100",     32'(strb), 32'hE);
    cyc(8990); chk("ms999",   32'(strb), 32'h8);
    cyc(10); chk("ms1000",    32'(strb), 32'hF);
    cyc(1);  chk("ms1000_one_cycle", 32'(strb), 32'h0);

    // pause at cnt=4 after ms1003, resume
    cyc(29); chk("ms1003", 32'(strb), 32'h8);
    cyc(2);
    bus.stop = 1'b1;
    cyc(3);
    chk("stop_run", 32'(bus.running), 32'h0);
    bus.stop = 1'b0;
    quiet("pause_quiet", 50);
    bus.start = 1'b1;
    cyc(2);
    bus.start = 1'b0;
    cyc(1);
    chk("resume_run", 32'(bus.running), 32'h1);
    cyc(5);  chk("resume_early", 32'(strb), 32'h0);
    cyc(1);  chk("resume_ms6",   32'(strb), 32'h8);
    cyc(50); chk("ms1009",       32'(strb), 32'h8);
    cyc(10); chk("ms1010",       32'(strb), 32'hC);

    // clear while d10=7
    cyc(70);
    bus.clr = 1'b1;
    cyc(2);
    chk("clr_e2", 32'({bus.running, bus.clr_out}), 32'h2);
    cyc(1);
    chk("clr_e3", 32'({bus.running, bus.clr_out}), 32'h1);
    bus.clr = 1'b0;
    cyc(1);
    chk("clr_out_one", 32'(bus.clr_out), 32'h0);
    quiet("idle_quiet", 5);
    bus.start = 1'b1;
    cyc(2);
    bus.start = 1'b0;
    cyc(1);
    chk("restart_run", 32'(bus.running), 32'h1);
    cyc(90); chk("fresh_ms9",  32'(strb), 32'h8);
    cyc(10); chk("fresh_ms10", 32'(strb), 32'hC);

    // simultaneous edges
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc(3);
    chk("ss_in_run", 32'(bus.running), 32'h0);
    bus.start = 1'b0; bus.stop = 1'b0;
    cyc(2);
    bus.clr = 1'b1; bus.start = 1'b1;
    cyc(3);
    chk("clr_start", 32'({bus.running, bus.clr_out}), 32'h1);
    bus.clr = 1'b0; bus.start = 1'b0;
    cyc(1);
    chk("clr_start_one", 32'(bus.clr_out), 32'h0);
    cyc(1);
    bus.clr = 1'b1;
    cyc(3);
    chk("clr_in_idle", 32'({bus.running, bus.clr_out}), 32'h1);
    bus.clr = 1'b0;
    cyc(1);
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc(3);
    chk("ss_in_idle", 32'(bus.running), 32'h1);
    bus.start = 1'b0; bus.stop = 1'b0;
    cyc(2);

    // START held 100 cycles: one transition only
    bus.stop = 1'b1;
    cyc(3);
    chk("hold_pre_pause", 32'(bus.running), 32'h0);
    bus.stop = 1'b0;
    cyc(2);
    bus.start = 1'b1;
    cyc(3);
    chk("hold_run", 32'(bus.running), 32'h1);
    cyc(17);
    bus.stop = 1'b1;
    cyc(3);
    chk("hold_stop", 32'(bus.running), 32'h0);
    bus.stop = 1'b0;
    cyc(77);
    chk("hold_no_rerun", 32'(bus.running), 32'h0);
    bus.start = 1'b0;
    cyc(3);

    // async reset mid-RUN
    bus.clr = 1'b1;
    cyc(3);
    bus.clr = 1'b0;
    cyc(2);
    bus.start = 1'b1;
    cyc(2);
    bus.start = 1'b0;
    cyc(1);
    chk("ar_run", 32'(bus.running), 32'h1);
    cyc(10);
    chk("ar_ms", 32'(outs), 32'h30);
    #2 rst_n = 1'b0;
    #1 chk("ar_async_drop", 32'(outs), 32'h0);
    cyc(3);
    rst_n = 1'b1;
    quiet("ar_after_release", 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
